// File: rtl/slurm16_mem_arbiter.sv
// Five-way arbiter for the single synchronous SRAM port: video reads first (round-robin),
// then flash DMA writes, then the CPU, which gets a forced grant after CPU_MAX_WAIT lost cycles.
module slurm16_mem_arbiter #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic                    CLK,
  input  logic                    RST,

  input  logic [ADDRESS_BITS-1:0] spcon_memory_address,
  output logic [BITS-1:0]         spcon_memory_data,
  input  logic                    spcon_rvalid,
  output logic                    spcon_rready,

  input  logic [ADDRESS_BITS-1:0] bg0_memory_address,
  output logic [BITS-1:0]         bg0_memory_data,
  input  logic                    bg0_rvalid,
  output logic                    bg0_rready,

  input  logic [ADDRESS_BITS-1:0] bg1_memory_address,
  output logic [BITS-1:0]         bg1_memory_data,
  input  logic                    bg1_rvalid,
  output logic                    bg1_rready,

  input  logic [ADDRESS_BITS-1:0] fl_memory_address,
  input  logic [BITS-1:0]         fl_memory_data,
  input  logic                    fl_wvalid,
  output logic                    fl_wready,

  input  logic [ADDRESS_BITS-1:0] cpu_addr,
  input  logic [BITS-1:0]         cpu_wdata,
  output logic [BITS-1:0]         cpu_rdata,
  input  logic                    cpu_wr,
  input  logic                    cpu_rd,
  input  logic [1:0]              cpu_wr_mask,
  output logic                    cpu_success,

  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [BITS-1:0]         mem_wdata,
  output logic                    mem_wr,
  output logic                    mem_rd,
  output logic [1:0]              mem_wr_mask,
  input  logic [BITS-1:0]         mem_rdata
);

  localparam logic [2:0] ID_SPCON = 3'd0;
  localparam logic [2:0] ID_BG0   = 3'd1;
  localparam logic [2:0] ID_BG1   = 3'd2;
  localparam logic [2:0] ID_FL    = 3'd3;
  localparam logic [2:0] ID_CPU   = 3'd4;
  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  // State
  logic                    inflight_vld_q, inflight_vld_d;
  logic [2:0]              inflight_id_q,  inflight_id_d;
  logic [1:0]              rr_ptr_q,       rr_ptr_d;
  logic [3:0]              wait_cnt_q,     wait_cnt_d;
  logic [ADDRESS_BITS-1:0] addr_hold_q,    addr_hold_d;
  logic [BITS-1:0]         wdata_hold_q,   wdata_hold_d;

  // Arbitration signals
  logic [2:0]              vid_active;
  logic [3:0]              vid_elig;
  logic                    vid_hit;
  logic [1:0]              vid_sel;
  logic [1:0]              vid_idx;
  logic                    fl_elig;
  logic                    cpu_active;
  logic                    cpu_elig;
  logic                    cpu_granted;
  logic                    grant_vld;
  logic [2:0]              grant_id;

  // Selected access
  logic [ADDRESS_BITS-1:0] vid_addr_sel;
  logic [ADDRESS_BITS-1:0] sel_addr;
  logic [BITS-1:0]         sel_wdata;
  logic                    sel_rd;
  logic                    sel_wr;
  logic [1:0]              sel_mask;

  assign vid_active  = {bg1_rvalid, bg0_rvalid, spcon_rvalid};
  assign vid_elig[3] = 1'b0;

  // A requester granted last cycle is masked while its completion is pending.
  for (genvar gi = 0; gi < 3; gi++) begin : g_vid_elig
    assign vid_elig[gi] = vid_active[gi] && !(inflight_vld_q && inflight_id_q == 3'(gi));
  end

  assign fl_elig    = fl_wvalid && !(inflight_vld_q && inflight_id_q == ID_FL);
  assign cpu_active = cpu_rd || cpu_wr;
  assign cpu_elig   = cpu_active && !(inflight_vld_q && inflight_id_q == ID_CPU);

  // Round-robin search over the video group starting at rr_ptr_q.
  always_comb begin
    vid_hit = 1'b0;
    vid_sel = 2'd0;
    vid_idx = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!vid_hit && vid_elig[vid_idx]) begin
        vid_hit = 1'b1;
        vid_sel = vid_idx;
      end
      vid_idx = (vid_idx == 2'd2) ? 2'd0 : vid_idx + 2'd1;
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ID_SPCON;
    if (cpu_elig && wait_cnt_q == MAX_WAIT) begin
      grant_vld = 1'b1;
      grant_id  = ID_CPU;
    end else if (vid_hit) begin
      grant_vld = 1'b1;
      grant_id  = {1'b0, vid_sel};
    end else if (fl_elig) begin
      grant_vld = 1'b1;
      grant_id  = ID_FL;
    end else if (cpu_elig) begin
      grant_vld = 1'b1;
      grant_id  = ID_CPU;
    end
  end

  assign cpu_granted = grant_vld && grant_id == ID_CPU;

  always_comb begin
    unique case (vid_sel)
      2'd1:    vid_addr_sel = bg0_memory_address;
      2'd2:    vid_addr_sel = bg1_memory_address;
      default: vid_addr_sel = spcon_memory_address;
    endcase
  end

  // Access encoding; address and write data hold their last values when idle.
  always_comb begin
    sel_addr  = addr_hold_q;
    sel_wdata = wdata_hold_q;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_mask  = 2'b00;
    if (grant_vld) begin
      case (grant_id)
        ID_FL: begin
          sel_addr  = fl_memory_address;
          sel_wdata = fl_memory_data;
          sel_wr    = 1'b1;
          sel_mask  = 2'b11;
        end
        ID_CPU: begin
          sel_addr = cpu_addr;
          if (cpu_wr) begin
            sel_wdata = cpu_wdata;
            sel_wr    = 1'b1;
            sel_mask  = cpu_wr_mask;
          end else begin
            sel_rd = 1'b1;
          end
        end
        default: begin
          sel_addr = vid_addr_sel;
          sel_rd   = 1'b1;
        end
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    inflight_vld_d = grant_vld;
    inflight_id_d  = grant_id;
    addr_hold_d    = sel_addr;
    wdata_hold_d   = sel_wdata;
    rr_ptr_d       = rr_ptr_q;
    if (grant_vld && grant_id < ID_FL) begin
      rr_ptr_d = (vid_sel == 2'd2) ? 2'd0 : vid_sel + 2'd1;
    end
    // Anything other than an eligible-but-losing CPU returns the counter to zero.
    wait_cnt_d = 4'd0;
    if (cpu_elig && !cpu_granted) begin
      wait_cnt_d = (wait_cnt_q == MAX_WAIT) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight_vld_q <= 1'b0;
      inflight_id_q  <= ID_SPCON;
      rr_ptr_q       <= 2'd0;
      wait_cnt_q     <= 4'd0;
      addr_hold_q    <= '0;
      wdata_hold_q   <= '0;
    end else begin
      inflight_vld_q <= inflight_vld_d;
      inflight_id_q  <= inflight_id_d;
      rr_ptr_q       <= rr_ptr_d;
      wait_cnt_q     <= wait_cnt_d;
      addr_hold_q    <= addr_hold_d;
      wdata_hold_q   <= wdata_hold_d;
    end
  end

  // SRAM port is quiet while reset is held, even if requests are pending.
  assign mem_addr    = RST ? '0 : sel_addr;
  assign mem_wdata   = RST ? '0 : sel_wdata;
  assign mem_rd      = !RST && sel_rd;
  assign mem_wr      = !RST && sel_wr;
  assign mem_wr_mask = RST ? 2'b00 : sel_mask;

  assign spcon_rready = inflight_vld_q && inflight_id_q == ID_SPCON;
  assign bg0_rready   = inflight_vld_q && inflight_id_q == ID_BG0;
  assign bg1_rready   = inflight_vld_q && inflight_id_q == ID_BG1;
  assign fl_wready    = inflight_vld_q && inflight_id_q == ID_FL;
  assign cpu_success  = inflight_vld_q && inflight_id_q == ID_CPU;

  assign spcon_memory_data = mem_rdata;
  assign bg0_memory_data   = mem_rdata;
  assign bg1_memory_data   = mem_rdata;
  assign cpu_rdata         = mem_rdata;

endmodule

// File: tb/tb_slurm16_mem_arbiter.sv
// Scoreboard bench for slurm16_mem_arbiter: each cycle's expected grant is checked on the SRAM
// port and queued; the queued completion is checked against the ready pulses one cycle later.
module tb_slurm16_mem_arbiter;

  localparam int ID_SP   = 0;
  localparam int ID_B0   = 1;
  localparam int ID_B1   = 2;
  localparam int ID_FL   = 3;
  localparam int ID_CPU  = 4;
  localparam int ID_NONE = 7;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] spcon_memory_address = '0, bg0_memory_address = '0, bg1_memory_address = '0;
  logic [15:0] spcon_memory_data, bg0_memory_data, bg1_memory_data;
  logic        spcon_rvalid = 1'b0, bg0_rvalid = 1'b0, bg1_rvalid = 1'b0;
  logic        spcon_rready, bg0_rready, bg1_rready;
  logic [15:0] fl_memory_address = '0, fl_memory_data = '0;
  logic        fl_wvalid = 1'b0, fl_wready;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_success;
  logic [1:0]  cpu_wr_mask = 2'b00;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        mem_wr, mem_rd;
  logic [1:0]  mem_wr_mask;

  typedef struct {
    int          id;
    logic        is_read;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] last_addr_exp = '0;

  slurm16_mem_arbiter #(.BITS(16), .ADDRESS_BITS(16), .CPU_MAX_WAIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .spcon_memory_address(spcon_memory_address), .spcon_memory_data(spcon_memory_data),
    .spcon_rvalid(spcon_rvalid), .spcon_rready(spcon_rready),
    .bg0_memory_address(bg0_memory_address), .bg0_memory_data(bg0_memory_data),
    .bg0_rvalid(bg0_rvalid), .bg0_rready(bg0_rready),
    .bg1_memory_address(bg1_memory_address), .bg1_memory_data(bg1_memory_data),
    .bg1_rvalid(bg1_rvalid), .bg1_rready(bg1_rready),
    .fl_memory_address(fl_memory_address), .fl_memory_data(fl_memory_data),
    .fl_wvalid(fl_wvalid), .fl_wready(fl_wready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_wr_mask(cpu_wr_mask), .cpu_success(cpu_success),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wr_mask(mem_wr_mask), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] rd_fn(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : ((a ^ 16'hA5C3) + 16'h0101);
  endfunction

  // SRAM model: read data appears the cycle after mem_rd.
  always @(posedge CLK) mem_rdata <= mem_rd ? rd_fn(mem_addr) : 16'h0000;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] addr_of(input int id);
    case (id)
      ID_SP:   return spcon_memory_address;
      ID_B0:   return bg0_memory_address;
      ID_B1:   return bg1_memory_address;
      ID_FL:   return fl_memory_address;
      default: return cpu_addr;
    endcase
  endfunction

  task automatic run_cycle(input int exp_id);
    exp_t        e;
    exp_t        n;
    logic [15:0] ea;
    logic [15:0] ewd;
    logic        er;
    logic        ew;
    logic [1:0]  em;
    @(negedge CLK);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else begin
      e.id = ID_NONE; e.is_read = 1'b0; e.data = '0;
    end
    check_value("ready_pulses",
                {27'd0, cpu_success, fl_wready, bg1_rready, bg0_rready, spcon_rready},
                (e.id == ID_NONE) ? 32'd0 : (32'd1 << e.id));
    if (e.is_read) begin
      case (e.id)
        ID_SP:   check_value("spcon_data", {16'd0, spcon_memory_data}, {16'd0, e.data});
        ID_B0:   check_value("bg0_data", {16'd0, bg0_memory_data}, {16'd0, e.data});
        ID_B1:   check_value("bg1_data", {16'd0, bg1_memory_data}, {16'd0, e.data});
        default: check_value("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.data});
      endcase
    end
    ea = last_addr_exp; ewd = '0; er = 1'b0; ew = 1'b0; em = 2'b00;
    case (exp_id)
      ID_SP, ID_B0, ID_B1: begin
        ea = addr_of(exp_id); er = 1'b1;
      end
      ID_FL: begin
        ea = fl_memory_address; ew = 1'b1; em = 2'b11; ewd = fl_memory_data;
      end
      ID_CPU: begin
        ea = cpu_addr;
        if (cpu_wr) begin
          ew = 1'b1; em = cpu_wr_mask; ewd = cpu_wdata;
        end else begin
          er = 1'b1;
        end
      end
      default: ;
    endcase
    check_value("mem_strobes", {28'd0, mem_rd, mem_wr, mem_wr_mask}, {28'd0, er, ew, em});
    check_value("mem_addr", {16'd0, mem_addr}, {16'd0, ea});
    if (ew) check_value("mem_wdata", {16'd0, mem_wdata}, {16'd0, ewd});
    n.id = exp_id; n.is_read = er; n.data = rd_fn(ea);
    sb_q.push_back(n);
    last_addr_exp = ea;
    if (exp_id != ID_NONE)
      $display("cycle %0d: grant id %0d addr %h rd %0b wr %0b mask %b", cyc, exp_id, ea, er, ew, em);
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    RST = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      check_value("rst_pulses",
                  {27'd0, cpu_success, fl_wready, bg1_rready, bg0_rready, spcon_rready}, 32'd0);
      check_value("rst_mem_ctrl", {28'd0, mem_rd, mem_wr, mem_wr_mask}, 32'd0);
      check_value("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      check_value("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      $display("cycle %0d: reset held", cyc);
      cyc++;
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
    sb_q.delete();
    last_addr_exp = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq3[11];
    seq3 = '{ID_SP, ID_B0, ID_B1, ID_SP, ID_CPU, ID_B0, ID_B1, ID_SP, ID_B0, ID_B1, ID_CPU};

    apply_reset(2);

    // Single background-0 read
    bg0_memory_address = 16'h1234; bg0_rvalid = 1'b1;
    run_cycle(ID_B0);
    bg0_rvalid = 1'b0;
    run_cycle(ID_NONE);
    run_cycle(ID_NONE);

    // Video round-robin
    apply_reset(1);
    spcon_memory_address = 16'h2000; bg0_memory_address = 16'h2100; bg1_memory_address = 16'h2200;
    spcon_rvalid = 1'b1; bg0_rvalid = 1'b1; bg1_rvalid = 1'b1;
    for (int i = 0; i < 9; i++) run_cycle(i % 3);
    spcon_rvalid = 1'b0; bg0_rvalid = 1'b0; bg1_rvalid = 1'b0;
    run_cycle(ID_NONE);

    // CPU bounded wait against saturated video traffic
    apply_reset(1);
    spcon_rvalid = 1'b1; bg0_rvalid = 1'b1; bg1_rvalid = 1'b1;
    cpu_addr = 16'h0C00; cpu_rd = 1'b1;
    for (int i = 0; i < 11; i++) run_cycle(seq3[i]);
    spcon_rvalid = 1'b0; bg0_rvalid = 1'b0; bg1_rvalid = 1'b0; cpu_rd = 1'b0;
    run_cycle(ID_NONE);

    // Flash beats CPU write, CPU follows next cycle
    apply_reset(1);
    fl_memory_address = 16'h0100; fl_memory_data = 16'hA55A; fl_wvalid = 1'b1;
    cpu_addr = 16'h0200; cpu_wdata = 16'h00CC; cpu_wr_mask = 2'b01; cpu_wr = 1'b1;
    run_cycle(ID_FL);
    fl_wvalid = 1'b0;
    run_cycle(ID_CPU);
    cpu_wr = 1'b0;
    run_cycle(ID_NONE);
    run_cycle(ID_NONE);

    // Read and write together is a write only
    cpu_addr = 16'h0300; cpu_wdata = 16'h1357; cpu_wr_mask = 2'b11; cpu_wr = 1'b1; cpu_rd = 1'b1;
    run_cycle(ID_CPU);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    run_cycle(ID_NONE);

    // CPU write with empty mask still completes
    cpu_addr = 16'h0310; cpu_wdata = 16'hFFFF; cpu_wr_mask = 2'b00; cpu_wr = 1'b1;
    run_cycle(ID_CPU);
    cpu_wr = 1'b0;
    run_cycle(ID_NONE);

    // Reset in the completion cycle of a bg1 grant
    apply_reset(1);
    bg1_memory_address = 16'h0BB1; bg1_rvalid = 1'b1;
    run_cycle(ID_B1);
    apply_reset(2);
    run_cycle(ID_B1);
    spcon_memory_address = 16'h0A50; spcon_rvalid = 1'b1;
    run_cycle(ID_SP);
    spcon_rvalid = 1'b0;
    run_cycle(ID_B1);
    bg1_rvalid = 1'b0;
    run_cycle(ID_NONE);
    run_cycle(ID_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slurm16_mem_arbiter.md
Name: slurm16_mem_arbiter

Overview:
Shares the single synchronous SRAM port among five requesters:
- sprite controller (spcon) read port
- background 0 read port
- background 1 read port
- flash DMA write port
- CPU data port (read/write, byte mask)

It sits inside the memory controller wrapper, between the port-controller DMA channels / CPU and the SRAM. Video fetches are favoured, flash DMA comes next, and the CPU has a bounded-wait guarantee. Throughput is one access per cycle with fixed 1-cycle completion latency.

Parameters:
BITS, 16, data width of every data bus
ADDRESS_BITS, 16, address width of every address bus
CPU_MAX_WAIT, 4, max consecutive cycles an eligible CPU request may lose arbitration before forced grant (1..15)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous reset, active-high
spcon_memory_address  in  ADDRESS_BITS  sprite read address, stable while spcon_rvalid
spcon_memory_data  out  BITS  sprite read data, valid only when spcon_rready
spcon_rvalid  in  1  sprite request
spcon_rready  out  1  sprite completion pulse
bg0_memory_address / bg0_memory_data / bg0_rvalid / bg0_rready  as spcon, background 0
bg1_memory_address / bg1_memory_data / bg1_rvalid / bg1_rready  as spcon, background 1
fl_memory_address  in  ADDRESS_BITS  flash DMA write address
fl_memory_data  in  BITS  flash DMA write data
fl_wvalid  in  1  flash write request
fl_wready  out  1  flash write completion pulse
cpu_addr  in  ADDRESS_BITS  CPU address
cpu_wdata  in  BITS  CPU write data
cpu_rdata  out  BITS  CPU read data, valid only when cpu_success
cpu_wr  in  1  CPU write request
cpu_rd  in  1  CPU read request
cpu_wr_mask  in  2  CPU byte enables [1]=high byte, [0]=low byte
cpu_success  out  1  CPU completion pulse
mem_addr  out  ADDRESS_BITS  SRAM address
mem_wdata  out  BITS  SRAM write data
mem_wr  out  1  SRAM write strobe
mem_rd  out  1  SRAM read strobe
mem_wr_mask  out  2  SRAM byte enables
mem_rdata  in  BITS  SRAM read data, valid the cycle after mem_rd

Behaviour:
Reset (async, RST=1):
- All ready/success outputs 0. mem_rd, mem_wr, mem_wr_mask, mem_addr and mem_wdata all 0.
- In-flight register cleared, round-robin pointer = spcon, CPU wait counter = 0.

Request and completion rules:
- A requester is active while its valid is high (CPU: cpu_rd|cpu_wr).
- It is eligible in cycle N if active AND it was not granted in cycle N-1. This masks the requester whose completion is pending.
- mem_* are driven combinationally from the cycle-N winner; the SRAM samples them on the N/N+1 edge.
- A registered in-flight ID (3 bits + valid) produces exactly one completion pulse in cycle N+1 for the winner: rready, wready or success.
- Read data: mem_rdata is broadcast to spcon/bg0/bg1_memory_data and cpu_rdata, meaningful only with the matching pulse.
- Requester obligation: drop valid in the completion cycle, or keep it high to issue a new access. A held-high requester can therefore be granted at most every other cycle.

Grant priority (cycle N, eligible set only):
1. CPU, if cpu_wait_cnt == CPU_MAX_WAIT.
2. Video group (spcon, bg0, bg1), round-robin. Search starts after the last video winner; the pointer updates only on a video grant.
3. Flash.
4. CPU.

Access encoding:
- Video grant: mem_rd=1, mem_wr=0, mem_wr_mask=00.
- Flash grant: mem_wr=1, mem_wr_mask=11, mem_wdata=fl_memory_data.
- CPU write (cpu_wr=1): mem_wr=1, mem_wr_mask=cpu_wr_mask, mem_wdata=cpu_wdata. cpu_wr and cpu_rd both high is treated as a write only.
- CPU read: mem_rd=1.
- CPU write with mask 00: the grant and success pulse still occur; the SRAM ignores the data.
- No winner: mem_rd=mem_wr=0, mem_wr_mask=00, mem_addr/mem_wdata hold their previous values.

CPU wait counter (4 bits):
- Increments, saturating at CPU_MAX_WAIT, each cycle the CPU is eligible but not granted.
- Clears on CPU grant or when the CPU is inactive.
- A cycle where the CPU is ineligible only because it was just granted leaves the counter at 0.

Reset mid-operation:
- The in-flight access is discarded; no completion pulse is issued after reset release.
- Arbitration restarts from the reset state.

Test Plan:
1. bg0_rvalid=1, address 0x1234, SRAM returns 0xBEEF; idle others -> mem_rd=1 with mem_addr=0x1234 in cycle N; bg0_rready=1 and bg0_memory_data=0xBEEF in N+1; no other ready pulses.
2. spcon, bg0 and bg1 held valid continuously -> grants rotate spcon,bg0,bg1,spcon,... Each requester sees rready no faster than every other cycle; no requester waits more than 3 cycles.
3. All three video ports and CPU read held continuously, CPU_MAX_WAIT=4 -> CPU granted after exactly 4 lost cycles, then counter=0. cpu_success pulses once per grant with correct cpu_rdata.
4. fl_wvalid with address 0x0100, data 0xA55A, concurrent with CPU write to 0x0200, mask 01, data 0x00CC -> flash granted first: mem_wr=1, mask 11. The CPU is granted the next cycle with mask 01; fl_wready then cpu_success pulse in successive cycles.
5. cpu_wr=cpu_rd=1 -> single write issued with mem_rd=0; one cpu_success pulse.
6. RST asserted the cycle after a bg1 grant -> no bg1_rready pulse and all outputs 0 during reset. After release, a held bg1_rvalid is re-granted with round-robin starting at spcon.
